// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding for the ALU.
// Also detects load-use hazards and supports external stall and flush.
module id_ex_operand_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [2:0]            id_alu_ctrl,
  input  logic                  id_a_src,
  input  logic                  id_b_src,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [XLEN-1:0]       mem_result,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic [XLEN-1:0]       wb_result,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [2:0]            alu_ctrl,
  output logic [XLEN-1:0]       ex_store_data,
  output logic [XLEN-1:0]       ex_pc,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  load_use_hazard
);

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       rs1;
    logic [XLEN-1:0]       rs2;
    logic [REG_ADDR_W-1:0] rs1_idx;
    logic [REG_ADDR_W-1:0] rs2_idx;
    logic [REG_ADDR_W-1:0] rd;
    logic [2:0]            alu_ctrl;
    logic                  a_src;
    logic                  b_src;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } ex_t;

  ex_t ex_q, ex_d;
  logic [XLEN-1:0] fwd_a, fwd_b;

  // EX/MEM wins over MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_a = ex_q.rs1;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_q.rs1_idx)) begin
      fwd_a = mem_result;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_q.rs1_idx)) begin
      fwd_a = wb_result;
    end
    fwd_b = ex_q.rs2;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_q.rs2_idx)) begin
      fwd_b = mem_result;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_q.rs2_idx)) begin
      fwd_b = wb_result;
    end
  end

  assign load_use_hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                           ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      // Keep operands current so data retiring from WB during the stall survives.
      ex_d.rs1 = fwd_a;
      ex_d.rs2 = fwd_b;
    end else if (load_use_hazard) begin
      ex_d = '0;
    end else begin
      ex_d.valid     = id_valid;
      ex_d.pc        = id_pc;
      ex_d.imm       = id_imm;
      ex_d.rs1       = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1)) ?
                       wb_result : id_rs1_data;
      ex_d.rs2       = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2)) ?
                       wb_result : id_rs2_data;
      ex_d.rs1_idx   = id_rs1;
      ex_d.rs2_idx   = id_rs2;
      ex_d.rd        = id_rd;
      ex_d.alu_ctrl  = id_alu_ctrl;
      ex_d.a_src     = id_a_src;
      ex_d.b_src     = id_b_src;
      ex_d.reg_write = id_valid && id_reg_write;
      ex_d.mem_read  = id_valid && id_mem_read;
      ex_d.mem_write = id_valid && id_mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign alu_a         = ex_q.a_src ? ex_q.pc : fwd_a;
  assign alu_b         = ex_q.b_src ? ex_q.imm : fwd_b;
  assign alu_ctrl      = ex_q.alu_ctrl;
  assign ex_store_data = fwd_b;
  assign ex_pc         = ex_q.pc;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus random traffic against
// an abstract model of the EX-stage contents.
module tb_id_ex_operand_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, id_valid, id_a_src, id_b_src, id_reg_write, id_mem_read, id_mem_write;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm, mem_result, wb_result;
  logic [RW-1:0]   id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic [2:0]      id_alu_ctrl, alu_ctrl;
  logic            stall, flush, mem_reg_write, wb_reg_write;
  logic            ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
  logic [XLEN-1:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [RW-1:0]   ex_rd;

  id_ex_operand_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
    .id_a_src(id_a_src), .id_b_src(id_b_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .stall(stall), .flush(flush),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .load_use_hazard(load_use_hazard)
  );

  // What the EX stage is architecturally holding.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc, imm, a, b;
    logic [RW-1:0]   ra, rb, rd;
    logic [2:0]      ctrl;
    logic            asrc, bsrc, rw, mr, mw;
  } mdl_t;

  mdl_t m, nx;
  int checks = 0;
  int errors = 0;

  function automatic logic [XLEN-1:0] fwd(input logic [RW-1:0] idx, input logic [XLEN-1:0] v);
    if (idx == 0) return v;
    if (mem_reg_write && mem_rd == idx) return mem_result;
    if (wb_reg_write && wb_rd == idx) return wb_result;
    return v;
  endfunction

  function automatic logic m_hazard();
    return m.valid && m.mr && (m.rd != 0) && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
  endfunction

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic settle_check();
    #1;
    chk("ex_valid", ex_valid, m.valid);
    chk("alu_a", alu_a, m.asrc ? m.pc : fwd(m.ra, m.a));
    chk("alu_b", alu_b, m.bsrc ? m.imm : fwd(m.rb, m.b));
    chk("alu_ctrl", alu_ctrl, m.ctrl);
    chk("store_data", ex_store_data, fwd(m.rb, m.b));
    chk("ex_pc", ex_pc, m.pc);
    chk("ex_rd", ex_rd, m.rd);
    chk("reg_write", ex_reg_write, m.rw);
    chk("mem_read", ex_mem_read, m.mr);
    chk("mem_write", ex_mem_write, m.mw);
    chk("hazard", load_use_hazard, m_hazard());
  endtask

  task automatic tick();
    if (rst || flush) begin
      nx = '0;
    end else if (stall) begin
      nx = m;
      nx.a = fwd(m.ra, m.a);
      nx.b = fwd(m.rb, m.b);
    end else if (m_hazard()) begin
      nx = '0;
    end else begin
      nx.valid = id_valid;
      nx.pc    = id_pc;
      nx.imm   = id_imm;
      nx.a     = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs1) ? wb_result : id_rs1_data;
      nx.b     = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs2) ? wb_result : id_rs2_data;
      nx.ra    = id_rs1;
      nx.rb    = id_rs2;
      nx.rd    = id_rd;
      nx.ctrl  = id_alu_ctrl;
      nx.asrc  = id_a_src;
      nx.bsrc  = id_b_src;
      nx.rw    = id_valid & id_reg_write;
      nx.mr    = id_valid & id_mem_read;
      nx.mw    = id_valid & id_mem_write;
    end
    @(posedge clk);
    #1;
    m = nx;
  endtask

  task automatic idle();
    rst = 0; id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_ctrl = 0; id_a_src = 0; id_b_src = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; stall = 0; flush = 0;
    mem_rd = 0; mem_reg_write = 0; mem_result = 0; wb_rd = 0; wb_reg_write = 0; wb_result = 0;
  endtask

  task automatic randomize_inputs();
    id_valid = 1'($urandom); id_pc = $urandom; id_rs1_data = $urandom;
    id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
    id_rd = 5'($urandom_range(0, 7)); id_alu_ctrl = 3'($urandom_range(0, 5));
    id_a_src = 1'($urandom); id_b_src = 1'($urandom); id_reg_write = 1'($urandom);
    id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
    stall = ($urandom_range(0, 3) == 0); flush = ($urandom_range(0, 7) == 0);
    mem_rd = 5'($urandom_range(0, 7)); mem_reg_write = 1'($urandom); mem_result = $urandom;
    wb_rd = 5'($urandom_range(0, 7)); wb_reg_write = 1'($urandom); wb_result = $urandom;
  endtask

  initial begin
    m = '0;
    // Reset with garbage on every input
    randomize_inputs(); rst = 1; tick();
    randomize_inputs(); rst = 1; tick();
    idle();
    settle_check();
    chk("rst_valid", ex_valid, 0); chk("rst_ctrl", alu_ctrl, 0);
    chk("rst_a", alu_a, 0); chk("rst_b", alu_b, 0);
    chk("rst_rw", ex_reg_write, 0); chk("rst_hz", load_use_hazard, 0);

    // Basic load
    id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rs1_data = 5; id_imm = 7; id_b_src = 1;
    settle_check(); tick();
    idle(); settle_check();
    chk("basic_a", alu_a, 5); chk("basic_b", alu_b, 7);
    chk("basic_ctrl", alu_ctrl, 0); chk("basic_valid", ex_valid, 1);

    // Forwarding priority
    id_valid = 1; id_rs1 = 3; id_rs1_data = 1; tick();
    idle();
    mem_rd = 3; mem_reg_write = 1; mem_result = 32'hAAAA;
    wb_rd = 3; wb_reg_write = 1; wb_result = 32'hBBBB;
    settle_check(); chk("fwd_mem", alu_a, 32'hAAAA);
    mem_reg_write = 0;
    settle_check(); chk("fwd_wb", alu_a, 32'hBBBB);
    idle(); id_valid = 1; id_rs1 = 0; id_rs1_data = 32'h77; tick();
    idle();
    mem_rd = 0; mem_reg_write = 1; mem_result = 32'hAAAA;
    wb_rd = 0; wb_reg_write = 1; wb_result = 32'hBBBB;
    settle_check(); chk("fwd_x0", alu_a, 32'h77);

    // Load-use hazard
    idle(); id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 4; tick();
    idle(); id_valid = 1; id_rs1 = 1; id_rs2 = 4;
    settle_check(); chk("lu_hz", load_use_hazard, 1);
    tick(); settle_check();
    chk("lu_valid", ex_valid, 0); chk("lu_mr", ex_mem_read, 0);

    // Stall refresh from WB
    idle(); id_valid = 1; id_rs2 = 6; id_rs2_data = 32'h10; id_alu_ctrl = 3'b011; tick();
    idle(); stall = 1; id_valid = 1; id_alu_ctrl = 3'b010; id_rs2 = 1; id_rs2_data = 32'h99;
    wb_rd = 6; wb_reg_write = 1; wb_result = 32'h1234;
    settle_check(); tick();
    wb_reg_write = 0; wb_result = 0;
    settle_check(); chk("stall_b2", alu_b, 32'h1234); chk("stall_ctrl2", alu_ctrl, 3'b011);
    tick();
    settle_check(); chk("stall_b3", alu_b, 32'h1234); chk("stall_ctrl3", alu_ctrl, 3'b011);
    tick();

    // Flush beats stall
    idle(); id_valid = 1; id_reg_write = 1; id_rd = 7; flush = 1; stall = 1; tick();
    idle(); settle_check(); chk("flush_valid", ex_valid, 0);

    // Capture bypass from WB
    id_valid = 1; id_rs1 = 9; id_rs1_data = 32'h11;
    wb_rd = 9; wb_reg_write = 1; wb_result = 32'h55; tick();
    idle(); settle_check(); chk("cap_byp", alu_a, 32'h55);

    // Invalid ID suppresses control bits
    id_valid = 0; id_reg_write = 1; id_mem_read = 1; id_mem_write = 1; id_rd = 5; tick();
    idle(); settle_check();
    chk("inv_rw", ex_reg_write, 0); chk("inv_mr", ex_mem_read, 0); chk("inv_rd", ex_rd, 5);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      rst = ($urandom_range(0, 63) == 0);
      settle_check();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
